// File: rtl/cgra_context_sequencer.sv
// Context loader and run sequencer for a CGRA: streams context words into per-PE caches, then steps
// a context pointer over run_len contexts for run_iter iterations. Define CGRA_CTX_ERR_EN for the sticky error flag.
module cgra_context_sequencer #(
  parameter int WIDTH     = 120,
  parameter int NUM_PE    = 16,
  parameter int CTX_DEPTH = 16,
  parameter int DRAIN_CYC = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WIDTH:0]    cfg_data,
  input  logic [3:0]        cfg_pe,
  input  logic              cfg_last,
  input  logic              run_req,
  input  logic [15:0]       run_len,
  input  logic [15:0]       run_iter,
  input  logic              abort,
  output logic [WIDTH:0]    pe_data,
  output logic [NUM_PE-1:0] pe_wr,
  output logic              start,
  output logic [15:0]       cp,
  output logic              ld_write,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CAP   = NUM_PE * CTX_DEPTH;
  localparam int CNT_W = $clog2(CAP + 1);
  localparam int DR_W  = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DR_W-1:0]  DRAIN_LAST = DR_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(CAP);
  localparam logic [NUM_PE-1:0] WR_ONE    = NUM_PE'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ARM   = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        cp_q, cp_d;
  logic [15:0]        len_q, len_d;
  logic [15:0]        iter_q, iter_d;
  logic [DR_W-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     pe_data_q, pe_data_d;
  logic [NUM_PE-1:0]  pe_wr_q, pe_wr_d;
  logic               start_q, start_d;
  logic               done_q, done_d;
  logic               xfer, drop;
  logic [15:0]        len_eff, iter_eff;
`ifdef CGRA_CTX_ERR_EN
  logic               err_q, err_d;
`endif

  // cfg_ready is gated by reset so every output reads 0 while RST_N is held low.
  assign cfg_ready = RST_N && ((state_q == IDLE) || (state_q == LOAD));
  assign xfer      = cfg_valid && cfg_ready;
  assign drop      = (int'(cfg_pe) >= NUM_PE) || (cnt_q == CNT_FULL);
  assign len_eff   = (run_len == 16'd0) ? 16'd1 : run_len;
  assign iter_eff  = (run_iter == 16'd0) ? 16'd1 : run_iter;

  always_comb begin
    state_d   = state_q;
    cp_d      = cp_q;
    len_d     = len_q;
    iter_d    = iter_q;
    drain_d   = drain_q;
    cnt_d     = cnt_q;
    pe_data_d = pe_data_q;
    pe_wr_d   = '0;
    start_d   = 1'b0;
    done_d    = 1'b0;
`ifdef CGRA_CTX_ERR_EN
    err_d     = err_q;
`endif

    // Transferred beats always advance the FSM; a dropped beat just produces no write strobe.
    if (xfer) begin
      if (!drop) begin
        cnt_d     = cnt_q + 1'b1;
        pe_wr_d   = WR_ONE << cfg_pe;
        pe_data_d = cfg_data;
      end else begin
`ifdef CGRA_CTX_ERR_EN
        err_d = 1'b1;
`endif
      end
      state_d = cfg_last ? ARM : LOAD;
    end

    case (state_q)
      ARM: begin
        if (run_req) begin
`ifdef CGRA_CTX_ERR_EN
          if (run_len == 16'd0) begin
            err_d = 1'b1;
          end else begin
            len_d   = run_len;
            iter_d  = iter_eff;
            start_d = 1'b1;
            cp_d    = 16'd0;
            state_d = RUN;
          end
`else
          len_d   = len_eff;
          iter_d  = iter_eff;
          start_d = 1'b1;
          cp_d    = 16'd0;
          state_d = RUN;
`endif
        end
      end
      RUN: begin
        if (cp_q == len_q - 16'd1) begin
          cp_d = 16'd0;
          if (iter_q > 16'd1) begin
            iter_d = iter_q - 16'd1;
          end else if (DRAIN_CYC == 0) begin
            state_d = IDLE;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            drain_d = '0;
            state_d = DRAIN;
          end
        end else begin
          cp_d = cp_q + 16'd1;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: ;
    endcase

    // Abort overrides everything above, including a beat or run request in the same cycle.
    if (abort) begin
      state_d = IDLE;
      cp_d    = 16'd0;
      pe_wr_d = '0;
      start_d = 1'b0;
      done_d  = 1'b0;
      cnt_d   = '0;
`ifdef CGRA_CTX_ERR_EN
      err_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      cp_q      <= 16'd0;
      drain_q   <= '0;
      cnt_q     <= '0;
      pe_data_q <= '0;
      pe_wr_q   <= '0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cp_q      <= cp_d;
      drain_q   <= drain_d;
      cnt_q     <= cnt_d;
      pe_data_q <= pe_data_d;
      pe_wr_q   <= pe_wr_d;
      start_q   <= start_d;
      done_q    <= done_d;
    end
  end

  // Run length and iteration count are only read in RUN after ARM has loaded them.
  always_ff @(posedge CLK) begin
    len_q  <= len_d;
    iter_q <= iter_d;
  end

`ifdef CGRA_CTX_ERR_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign pe_data  = pe_data_q;
  assign pe_wr    = pe_wr_q;
  assign start    = start_q;
  assign cp       = cp_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);
  assign ld_write = (state_q == RUN) && (cp_q == len_q - 16'd1);

endmodule
